// File: rtl/regfile_scoreboard.sv
// 32x32 register file with a three-stage (EX/MEM/WB) destination scoreboard.
// Ports: Clk, Reset (sync, active-high), IssueValid/IssueDst (decode issue),
//   WbEnable/WbDst/WbData (write-back), Regfile_flat (all registers),
//   RdEx/RdMem/RdWb (one-hot busy masks per stage), ScoreboardError (sticky).
module regfile_scoreboard (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          IssueValid,
    input  logic [4:0]    IssueDst,
    input  logic          WbEnable,
    input  logic [4:0]    WbDst,
    input  logic [31:0]   WbData,
    output logic [1023:0] Regfile_flat,
    output logic [31:0]   RdEx,
    output logic [31:0]   RdMem,
    output logic [31:0]   RdWb,
    output logic          ScoreboardError
);

    logic [31:0] regs [32];

    logic       ex_valid;
    logic [4:0] ex_dst;
    logic       mem_valid;
    logic [4:0] mem_dst;
    logic       wb_valid;
    logic [4:0] wb_dst;
    logic       err;

    logic wb_write;
    logic wb_mismatch;

    assign wb_write    = WbEnable && (WbDst != 5'd0);
    assign wb_mismatch = wb_write && (!wb_valid || (WbDst != wb_dst));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
            ex_valid  <= 1'b0;
            ex_dst    <= 5'd0;
            mem_valid <= 1'b0;
            mem_dst   <= 5'd0;
            wb_valid  <= 1'b0;
            wb_dst    <= 5'd0;
            err       <= 1'b0;
        end else begin
            if (wb_write) begin
                regs[WbDst] <= WbData;
            end
            // Issues to x0 never occupy a stage, so x0 is never busy.
            ex_valid  <= IssueValid && (IssueDst != 5'd0);
            ex_dst    <= IssueDst;
            mem_valid <= ex_valid;
            mem_dst   <= ex_dst;
            wb_valid  <= mem_valid;
            wb_dst    <= mem_dst;
            if (wb_mismatch) begin
                err <= 1'b1;
            end
        end
    end

    // Register 0 is never written, so its slice stays at the reset value.
    always_comb begin
        Regfile_flat = '0;
        for (int n = 0; n < 32; n++) begin
            Regfile_flat[1023-32*n -: 32] = regs[n];
        end
    end

    function automatic logic [31:0] onehot(input logic v, input logic [4:0] d);
        logic [31:0] m;
        m = 32'd0;
        if (v) begin
            m[d] = 1'b1;
        end
        m[0] = 1'b0;
        return m;
    endfunction

    assign RdEx            = onehot(ex_valid, ex_dst);
    assign RdMem           = onehot(mem_valid, mem_dst);
    assign RdWb            = onehot(wb_valid, wb_dst);
    assign ScoreboardError = err;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomized and directed bench for regfile_scoreboard against a
// queue-based model of in-flight destinations and an array register file.
module tb_regfile_scoreboard;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          IssueValid;
    logic [4:0]    IssueDst;
    logic          WbEnable;
    logic [4:0]    WbDst;
    logic [31:0]   WbData;
    logic [1023:0] Regfile_flat;
    logic [31:0]   RdEx;
    logic [31:0]   RdMem;
    logic [31:0]   RdWb;
    logic          ScoreboardError;

    regfile_scoreboard dut (
        .Clk(Clk),
        .Reset(Reset),
        .IssueValid(IssueValid),
        .IssueDst(IssueDst),
        .WbEnable(WbEnable),
        .WbDst(WbDst),
        .WbData(WbData),
        .Regfile_flat(Regfile_flat),
        .RdEx(RdEx),
        .RdMem(RdMem),
        .RdWb(RdWb),
        .ScoreboardError(ScoreboardError)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // Model: registers, and the destinations issued 1, 2, 3 edges ago
    // (0 = nothing in flight). Index 0 is the most recent issue.
    logic [31:0] mregs [32];
    int          hist [$];
    bit          merr;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] busy(input int d);
        logic [31:0] m;
        m = 32'd0;
        if (d != 0) m = 32'd1 << d;
        return m;
    endfunction

    function automatic logic [31:0] slice(input int n);
        return Regfile_flat[1023-32*n -: 32];
    endfunction

    task automatic tick();
        int in_wb;
        @(posedge Clk);
        in_wb = hist[2];
        if (Reset) begin
            for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
            hist = '{0, 0, 0};
            merr = 1'b0;
        end else begin
            if (WbEnable && WbDst != 5'd0) begin
                if (int'(WbDst) != in_wb) merr = 1'b1;
                mregs[WbDst] = WbData;
            end
            hist.push_front(IssueValid ? int'(IssueDst) : 0);
            void'(hist.pop_back());
        end
        #1;
        chk("rd_ex", RdEx, busy(hist[0]));
        chk("rd_mem", RdMem, busy(hist[1]));
        chk("rd_wb", RdWb, busy(hist[2]));
        chk("sb_err", {31'd0, ScoreboardError}, {31'd0, merr});
        for (int n = 0; n < 32; n++) begin
            chk($sformatf("reg%0d", n), slice(n), mregs[n]);
        end
    endtask

    task automatic idle();
        Reset = 1'b0;
        IssueValid = 1'b0;
        IssueDst = 5'd0;
        WbEnable = 1'b0;
        WbDst = 5'd0;
        WbData = 32'd0;
    endtask

    task automatic do_reset();
        idle();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    initial begin
        hist = '{0, 0, 0};
        merr = 1'b0;
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        idle();
        do_reset();
        chk("rst_flat_r5", slice(5), 32'd0);

        // Basic tracking of x5
        IssueValid = 1'b1; IssueDst = 5'd5;
        tick();
        chk("basic_ex", RdEx, 32'h20);
        idle();
        tick();
        chk("basic_mem", RdMem, 32'h20);
        tick();
        chk("basic_wb", RdWb, 32'h20);
        WbEnable = 1'b1; WbDst = 5'd5; WbData = 32'hDEADBEEF;
        tick();
        idle();
        chk("basic_wb_clr", RdWb, 32'h0);
        chk("basic_r5", Regfile_flat[863:832], 32'hDEADBEEF);
        chk("basic_err", {31'd0, ScoreboardError}, 32'd0);

        // Register 0
        IssueValid = 1'b1; IssueDst = 5'd0;
        WbEnable = 1'b1; WbDst = 5'd0; WbData = 32'hFFFFFFFF;
        tick();
        idle();
        for (int i = 0; i < 3; i++) tick();
        chk("r0_flat", Regfile_flat[1023:992], 32'h0);
        chk("r0_err", {31'd0, ScoreboardError}, 32'd0);

        // Back-to-back writers of x7
        for (int i = 0; i < 6; i++) begin
            idle();
            if (i < 3) begin IssueValid = 1'b1; IssueDst = 5'd7; end
            if (i >= 3) begin
                WbEnable = 1'b1; WbDst = 5'd7; WbData = 32'h700 + i;
            end
            tick();
            if (i == 2) begin
                chk("b2b_all", RdEx & RdMem & RdWb, 32'h80);
            end
            chk($sformatf("b2b_busy%0d", i), (RdEx | RdMem | RdWb) & 32'h80,
                (i < 5) ? 32'h80 : 32'h0);
        end
        idle();
        chk("b2b_r7", slice(7), 32'h705);
        chk("b2b_err", {31'd0, ScoreboardError}, 32'd0);

        // Mismatch: x3 in flight, x4 written back
        IssueValid = 1'b1; IssueDst = 5'd3;
        tick();
        idle();
        tick();
        tick();
        WbEnable = 1'b1; WbDst = 5'd4; WbData = 32'h12345678;
        tick();
        idle();
        chk("mm_err", {31'd0, ScoreboardError}, 32'd1);
        chk("mm_r4", slice(4), 32'h12345678);
        chk("mm_r3", slice(3), 32'h0);
        tick();
        chk("mm_sticky", {31'd0, ScoreboardError}, 32'd1);

        // Reset mid-flight
        IssueValid = 1'b1; IssueDst = 5'd9;
        tick();
        IssueDst = 5'd10;
        tick();
        Reset = 1'b1;
        WbEnable = 1'b1; WbDst = 5'd6; WbData = 32'hABCD;
        tick();
        idle();
        chk("rmf_masks", RdEx | RdMem | RdWb, 32'h0);
        chk("rmf_r4", slice(4), 32'h0);
        chk("rmf_err", {31'd0, ScoreboardError}, 32'd0);
        tick();
        WbEnable = 1'b1; WbDst = 5'd9; WbData = 32'h99;
        tick();
        idle();
        chk("rmf_late_err", {31'd0, ScoreboardError}, 32'd1);

        // Full sweep
        do_reset();
        for (int n = 1; n < 32; n++) begin
            WbEnable = 1'b1; WbDst = 5'(n); WbData = 32'h100 + n;
            tick();
        end
        idle();
        for (int n = 0; n < 32; n++) begin
            chk($sformatf("sweep%0d", n), slice(n),
                (n == 0) ? 32'h0 : 32'h100 + n);
        end

        // Random traffic
        do_reset();
        for (int c = 0; c < 400; c++) begin
            idle();
            Reset = ($urandom_range(0, 49) == 0);
            IssueValid = $urandom_range(0, 3) != 0;
            IssueDst = 5'($urandom_range(0, 31));
            WbData = $urandom;
            if (hist[2] != 0) begin
                WbEnable = $urandom_range(0, 9) != 0;
                WbDst = ($urandom_range(0, 9) == 0) ?
                        5'($urandom_range(0, 31)) : 5'(hist[2]);
            end else begin
                WbEnable = $urandom_range(0, 9) == 0;
                WbDst = 5'($urandom_range(0, 31));
            end
            tick();
        end
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
